// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder: size codes,
// FSM state encoding and a helper that flags size codes the responder rejects.
package dmem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

    // Unsigned sizes only make sense for loads.
    function automatic logic ctrl_illegal(input logic we, input logic [2:0] ctrl);
        logic bad;
        bad = (ctrl == 3'b011) || (ctrl == 3'b110) || (ctrl == 3'b111);
        return bad || (we && ctrl[2]);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store initiator and dmem_responder.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_ctrl;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_ctrl, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_ctrl, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for dmem_responder: store byte enables / replicated data
// and load lane extraction with sign or zero extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  ctrl,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_byte = rword[{addr_lo, 3'b000} +: 8];
    assign ld_half = addr_lo[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        byte_en    = 4'b0000;
        wdata_lane = 32'h0;
        rdata_ext  = 32'h0;
        unique case (ctrl)
            SZ_B: begin
                byte_en    = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {{24{ld_byte[7]}}, ld_byte};
            end
            SZ_H: begin
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {{16{ld_half[15]}}, ld_half};
            end
            SZ_W: begin
                byte_en    = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = rword;
            end
            SZ_BU: rdata_ext = {24'h0, ld_byte};
            SZ_HU: rdata_ext = {16'h0, ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with byte-lane stores and
// sign/zero-extended loads. Wait states are built only with DMEM_WAITSTATE_EN.
//
// state   | meaning
// IDLE    | ready for a request (req_ready=1)
// WAIT    | wait states counting down (DMEM_WAITSTATE_EN only)
// RESP    | response held until rsp_ready
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus
);

    localparam int unsigned AW         = $clog2(DEPTH_WORDS);
    localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;

    if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("DEPTH_WORDS must be a power of two >= 2");
    end
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("WAIT_CYCLES must be in 1..15");
    end

    dmem_state_t state_q, state_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        commit;

    logic        acc_we;
    logic [2:0]  acc_ctrl;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_err;

    logic [AW-1:0] idx;
    logic [31:0]   rword;
    logic [3:0]    byte_en;
    logic [31:0]   wdata_lane;
    logic [31:0]   rdata_ext;
    logic          mem_we;
    logic [31:0]   mem_q [DEPTH_WORDS];

`ifdef DMEM_WAITSTATE_EN
    logic        we_q, we_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  cnt_q, cnt_d;

    assign acc_we    = we_q;
    assign acc_ctrl  = ctrl_q;
    assign acc_addr  = addr_q;
    assign acc_wdata = wdata_q;
`else
    // Without wait states the access completes on the accepting edge,
    // so the datapath works straight from the bus.
    assign acc_we    = bus.req_we;
    assign acc_ctrl  = bus.req_ctrl;
    assign acc_addr  = bus.req_addr;
    assign acc_wdata = bus.req_wdata;
`endif

    always_comb begin
        acc_err = ctrl_illegal(acc_we, acc_ctrl);
        if (acc_ctrl[1:0] == 2'b01 && acc_addr[0])
            acc_err = 1'b1;
        if (acc_ctrl == SZ_W && acc_addr[1:0] != 2'b00)
            acc_err = 1'b1;
        if ({1'b0, acc_addr} >= BYTE_LIMIT)
            acc_err = 1'b1;
    end

    assign idx   = acc_addr[AW+1:2];
    assign rword = mem_q[idx];

    dmem_lane_align u_lane_align (
        .ctrl       (acc_ctrl),
        .addr_lo    (acc_addr[1:0]),
        .wdata      (acc_wdata),
        .rword      (rword),
        .byte_en    (byte_en),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext)
    );

    always_comb begin
        state_d     = state_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        commit      = 1'b0;
`ifdef DMEM_WAITSTATE_EN
        we_d    = we_q;
        ctrl_d  = ctrl_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
`ifdef DMEM_WAITSTATE_EN
                    we_d    = bus.req_we;
                    ctrl_d  = bus.req_ctrl;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    cnt_d   = 4'(WAIT_CYCLES - 1);
                    state_d = ST_WAIT;
`else
                    commit  = 1'b1;
                    state_d = ST_RESP;
`endif
                end
            end
`ifdef DMEM_WAITSTATE_EN
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`endif
            ST_RESP: begin
                if (bus.rsp_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (commit) begin
            rsp_err_d   = acc_err;
            rsp_rdata_d = (acc_we || acc_err) ? 32'h0 : rdata_ext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
`ifdef DMEM_WAITSTATE_EN
            we_q    <= 1'b0;
            ctrl_q  <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            cnt_q   <= 4'd0;
`endif
        end else begin
            state_q     <= state_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef DMEM_WAITSTATE_EN
            we_q    <= we_d;
            ctrl_q  <= ctrl_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Storage is deliberately not reset; commit only fires from a live WAIT/IDLE state.
    assign mem_we = commit && acc_we && !acc_err;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i])
                    mem_q[idx][8*i +: 8] <= wdata_lane[8*i +: 8];
            end
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a byte-array
// memory model; expected latency follows DMEM_WAITSTATE_EN.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned WAITS = 2;
`ifdef DMEM_WAITSTATE_EN
    localparam int LAT = WAITS + 1;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    logic [7:0] model_mem [DEPTH*4];

    dmem_responder_if bus ();

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (WAITS)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    task automatic model_access(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic [31:0] rdata,
                                output logic err);
        int nb;
        logic [31:0] v;
        nb  = (ctrl[1:0] == 2'd0) ? 1 : (ctrl[1:0] == 2'd1) ? 2 : 4;
        err = (ctrl == 3'd3) || (ctrl == 3'd6) || (ctrl == 3'd7) || (we && ctrl[2]) ||
              ((addr % 32'(nb)) != 0) || (addr >= 32'(DEPTH * 4));
        rdata = 32'h0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < nb; i++)
                    model_mem[int'(addr) + i] = wdata[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < nb; i++)
                    v[8*i +: 8] = model_mem[int'(addr) + i];
                if (!ctrl[2] && nb == 1) v = {{24{v[7]}}, v[7:0]};
                if (!ctrl[2] && nb == 2) v = {{16{v[15]}}, v[15:0]};
                rdata = v;
            end
        end
    endtask

    task automatic do_txn(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                          input logic [31:0] wdata, input int stall, output logic [31:0] rdata);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          cyc;
        model_access(we, ctrl, addr, wdata, exp_rd, exp_err);
        @(negedge clk);
        bus.rsp_ready = (stall == 0);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_ctrl  = ctrl;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        cyc = 0;
        while (!bus.req_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("accept_timeout", 32'(cyc >= 50), 32'd0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        cyc = 1;
        while (!bus.rsp_valid && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("latency", 32'(cyc), 32'(LAT));
        check("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
        check("rsp_rdata", bus.rsp_rdata, exp_rd);
        rdata = bus.rsp_rdata;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check("stall_valid", 32'(bus.rsp_valid), 32'd1);
            check("stall_rdata", bus.rsp_rdata, exp_rd);
            check("stall_err", 32'(bus.rsp_err), 32'(exp_err));
            check("stall_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rsp_drop", 32'(bus.rsp_valid), 32'd0);
        check("back_idle", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic reset_mid_store();
        logic [31:0] rd;
        logic        e;
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_ctrl  = SZ_W;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
`ifndef DMEM_WAITSTATE_EN
        // Zero-wait build: the store already committed on the accepting edge.
        model_access(1'b1, SZ_W, 32'h20, 32'h12345678, rd, e);
`endif
        reset = 1'b1;
        #1;
        check("rst_mid_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_mid_rdata", bus.rsp_rdata, 32'h0);
        check("rst_mid_err", 32'(bus.rsp_err), 32'd0);
        check("rst_mid_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        do_txn(1'b0, SZ_W, 32'h20, 32'h0, 0, rd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        logic [2:0]  c;
        n_checks      = 0;
        n_pass        = 0;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_ctrl  = 3'b000;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.rsp_ready = 1'b1;

        #12;
        check("reset_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rdata", bus.rsp_rdata, 32'h0);
        check("reset_err", 32'(bus.rsp_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("reset_ready", 32'(bus.req_ready), 32'd1);

        for (int w = 0; w < int'(DEPTH); w++)
            do_txn(1'b1, SZ_W, 32'(w * 4), $urandom, 0, rd);

        do_txn(1'b1, SZ_W, 32'h10, 32'hDEADBEEF, 0, rd);
        do_txn(1'b0, SZ_W, 32'h10, 32'h0, 0, rd);
        check("lw_deadbeef", rd, 32'hDEADBEEF);
        do_txn(1'b1, SZ_B, 32'h11, 32'h80, 0, rd);
        do_txn(1'b0, SZ_B, 32'h11, 32'h0, 0, rd);
        check("lb_signext", rd, 32'hFFFFFF80);
        do_txn(1'b0, SZ_BU, 32'h11, 32'h0, 0, rd);
        check("lbu_zeroext", rd, 32'h00000080);
        do_txn(1'b0, SZ_W, 32'h10, 32'h0, 0, rd);
        check("lw_after_sb", rd, 32'hDEAD80EF);

        do_txn(1'b0, SZ_H, 32'h13, 32'h0, 0, rd);
        do_txn(1'b1, SZ_W, 32'h400, 32'hFFFFFFFF, 0, rd);
        do_txn(1'b0, SZ_W, 32'h0, 32'h0, 0, rd);
        do_txn(1'b1, SZ_BU, 32'h4, 32'h55, 0, rd);
        do_txn(1'b0, SZ_W, 32'h4, 32'h0, 0, rd);

        do_txn(1'b0, SZ_W, 32'h10, 32'h0, 5, rd);
        reset_mid_store();

        for (int n = 0; n < 300; n++) begin
            c = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0)
                a = $urandom;
            else
                a = 32'($urandom_range(0, DEPTH * 4 - 1));
            do_txn(1'($urandom_range(0, 1)), c, a, $urandom, $urandom_range(0, 2), rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, giving the number of 32-bit storage words (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, giving the number of wait-state cycles per access (range 1..15).
REQ-003 SHALL have a single clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  initiator presents a request.
REQ-007 req_ready  output  1  responder accepts the request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_ctrl  input  3  funct3 size code: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, right-aligned.
REQ-012 rsp_valid  output  1  response is available.
REQ-013 rsp_ready  input  1  initiator takes the response.
REQ-014 rsp_rdata  output  32  load result after extension; 0 for stores and errors.
REQ-015 rsp_err  output  1  request was rejected (misaligned, out of range or illegal code).

Function
REQ-016 SHALL implement an FSM with states IDLE, WAIT and RESP, holding one request outstanding at most.
REQ-017 req_ready SHALL be 1 only in IDLE; a transfer occurs on req_valid && req_ready, and the responder SHALL latch we, ctrl, addr and wdata at that edge.
REQ-018 From IDLE, after acceptance, the FSM SHALL go to WAIT with counter = WAIT_CYCLES-1, decrement once per cycle, and enter RESP on the cycle after the counter reads 0.
REQ-019 RESP SHALL hold rsp_valid=1 with stable rsp_rdata and rsp_err until rsp_ready=1, then return to IDLE on that edge; no new request SHALL be accepted in the same cycle.
REQ-020 Error conditions: halfword with addr[0]=1; word with addr[1:0]!=0; addr >= DEPTH_WORDS*4; ctrl in {011,110,111}; store with ctrl[2]=1.
REQ-021 An erroring request SHALL produce rsp_err=1 and rsp_rdata=0, and SHALL NOT modify storage.
REQ-022 A store SHALL commit on the WAIT->RESP edge, writing only the addressed byte lane(s): sb lane addr[1:0], sh lanes addr[1]*2 and +1, sw all four lanes.
REQ-023 A load SHALL capture rsp_rdata on the WAIT->RESP edge, extracting the lane from addr[1:0] and sign-extending (000, 001) or zero-extending (100, 101).
REQ-024 The word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher bits are used only for the range check.
REQ-025 A load immediately following a store to the same word SHALL return the post-store value.

Reset
REQ-026 On reset assertion, the FSM SHALL go to IDLE immediately, with req_ready=1 after release, rsp_valid=0, rsp_rdata=0, rsp_err=0 and counter=0.
REQ-027 Storage contents SHALL NOT be reset; a store in WAIT when reset asserts SHALL be discarded and not committed.

Configuration
REQ-028 Macro DMEM_WAITSTATE_EN: when defined, behaviour is per REQ-018. When undefined, the WAIT state and counter SHALL be absent, IDLE SHALL go directly to RESP with the commit/capture on that edge (1-cycle latency), and WAIT_CYCLES SHALL be ignored.

Structure
REQ-029 Package dmem_pkg SHALL hold the size-code constants (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU) and the FSM state enum type.
REQ-030 A combinational sub-module dmem_lane_align SHALL perform the store byte-enable/data steering and the load lane extract/extend; the FSM, counter and storage reside in dmem_responder.

Verification
REQ-031 With WAITSTATE_EN and WAIT_CYCLES=2: sw addr 0x10 data 0xDEADBEEF, accepted at cycle t -> rsp_valid at t+3, err=0; then lw 0x10 -> rdata 0xDEADBEEF.
REQ-032 After REQ-031: sb addr 0x11 data 0x80, then lb 0x11 -> 0xFFFFFF80, lbu 0x11 -> 0x00000080, lw 0x10 -> 0xDEAD80EF.
REQ-033 lh addr 0x13 -> err=1, rdata=0; sw addr 0x400 (DEPTH 256) -> err=1, and a subsequent lw 0x000 is unchanged.
REQ-034 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rdata and err remain stable and req_ready=0; rsp_ready=1 -> IDLE on the next edge.
REQ-035 Assert reset during WAIT of sw 0x20 0x12345678 -> outputs return to reset values immediately; lw 0x20 afterwards returns the prior contents.
REQ-036 With DMEM_WAITSTATE_EN undefined: lw accepted at t -> rsp_valid at t+1.
